// File: rtl/axi_chan_slice_buf.sv
// ============================================================================
// Module      : axi_chan_slice_buf
// Description : Valid/ready buffer stage for one AXI channel. It can act as a
//               combinational bypass or as a circular FIFO, and has a hold input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_chan_slice_buf #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int MODE   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DATA_W-1:0]            in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_W-1:0]            out_data_o,
  input  logic                         hold_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (MODE == 0) begin : g_bypass
      assign out_valid_o = in_valid_i & ~hold_i;
      assign in_ready_o  = out_ready_i & ~hold_i;
      assign out_data_o  = in_data_i;
      assign count_o     = '0;
      assign empty_o     = 1'b1;
      assign full_o      = 1'b0;
    end else begin : g_fifo
      logic [DATA_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0]  wr_ptr;
      logic [PTR_W-1:0]  rd_ptr;
      logic [CNT_W-1:0]  count;
      logic              full;
      logic              empty;
      logic              push;
      logic              pop;

      assign full  = (count == CNT_W'(DEPTH));
      assign empty = (count == '0);

      // Ready depends only on occupancy and hold, so a pop never frees a slot
      // within the same cycle; that keeps out_ready_i off the upstream path.
      assign in_ready_o  = ~full & ~hold_i;
      assign out_valid_o = ~empty;
      assign out_data_o  = mem[rd_ptr];
      assign count_o     = count;
      assign empty_o     = empty;
      assign full_o      = full;

      assign push = in_valid_i & ~full & ~hold_i;
      assign pop  = ~empty & out_ready_i;

      // Storage is left unreset; its contents are only visible when valid.
      always_ff @(posedge clk) begin
        if (push) begin
          mem[wr_ptr] <= in_data_i;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (push) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
          end
          if (pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
          end
          case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
          endcase
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_axi_chan_slice_buf.sv
// ============================================================================
// Module      : tb_axi_chan_slice_buf
// Description : Self-checking bench for axi_chan_slice_buf in several configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_chan_slice_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // a: MODE1 DEPTH2, c: MODE1 DEPTH3, e: MODE1 DEPTH5, b: MODE0 bypass
  logic a_iv, a_ir, a_ov, a_or, a_hold, a_empty, a_full;
  logic [7:0] a_id, a_od;
  logic [1:0] a_cnt;
  logic c_iv, c_ir, c_ov, c_or, c_hold, c_empty, c_full;
  logic [7:0] c_id, c_od;
  logic [1:0] c_cnt;
  logic e_iv, e_ir, e_ov, e_or, e_hold, e_empty, e_full;
  logic [7:0] e_id, e_od;
  logic [2:0] e_cnt;
  logic b_iv, b_ir, b_ov, b_or, b_hold, b_empty, b_full;
  logic [7:0] b_id, b_od;
  logic [1:0] b_cnt;

  axi_chan_slice_buf #(.DATA_W(8), .DEPTH(2), .MODE(1)) u_a (
    .clk(clk), .rst(rst), .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_id),
    .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od), .hold_i(a_hold),
    .count_o(a_cnt), .empty_o(a_empty), .full_o(a_full));

  axi_chan_slice_buf #(.DATA_W(8), .DEPTH(3), .MODE(1)) u_c (
    .clk(clk), .rst(rst), .in_valid_i(c_iv), .in_ready_o(c_ir), .in_data_i(c_id),
    .out_valid_o(c_ov), .out_ready_i(c_or), .out_data_o(c_od), .hold_i(c_hold),
    .count_o(c_cnt), .empty_o(c_empty), .full_o(c_full));

  axi_chan_slice_buf #(.DATA_W(8), .DEPTH(5), .MODE(1)) u_e (
    .clk(clk), .rst(rst), .in_valid_i(e_iv), .in_ready_o(e_ir), .in_data_i(e_id),
    .out_valid_o(e_ov), .out_ready_i(e_or), .out_data_o(e_od), .hold_i(e_hold),
    .count_o(e_cnt), .empty_o(e_empty), .full_o(e_full));

  axi_chan_slice_buf #(.DATA_W(8), .DEPTH(2), .MODE(0)) u_b (
    .clk(clk), .rst(rst), .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_id),
    .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od), .hold_i(b_hold),
    .count_o(b_cnt), .empty_o(b_empty), .full_o(b_full));

  task automatic test_reset;
    @(negedge clk);
    #1;
    tests++; if ({a_ov, a_cnt, a_empty, a_full, a_ir} !== 6'b0_00_101) begin
      fails++; $display("FAIL reset_a: got %b expected 000101", {a_ov, a_cnt, a_empty, a_full, a_ir}); end
    tests++; if ({c_ov, c_cnt, c_empty, c_full, c_ir} !== 6'b0_00_101) begin
      fails++; $display("FAIL reset_c: got %b expected 000101", {c_ov, c_cnt, c_empty, c_full, c_ir}); end
    tests++; if ({e_ov, e_cnt, e_empty, e_full, e_ir} !== 7'b0_000_101) begin
      fails++; $display("FAIL reset_e: got %b expected 0000101", {e_ov, e_cnt, e_empty, e_full, e_ir}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream;
    a_or = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      a_iv = 1'b1; a_id = 8'(i);
      #1;
      tests++; if (a_ir !== 1'b1) begin
        fails++; $display("FAIL stream_ready beat %0d: got %b expected 1", i, a_ir); end
      tests++; if (a_cnt > 2'd1) begin
        fails++; $display("FAIL stream_count beat %0d: got %0d expected <=1", i, a_cnt); end
      tests++; if (a_ov !== (i != 1)) begin
        fails++; $display("FAIL stream_valid beat %0d: got %b expected %b", i, a_ov, (i != 1)); end
      if (i != 1) begin
        tests++; if (a_od !== 8'(i - 1)) begin
          fails++; $display("FAIL stream_data beat %0d: got %0h expected %0h", i, a_od, i - 1); end
      end
    end
    @(negedge clk);
    a_iv = 1'b0;
    #1;
    tests++; if (a_ov !== 1'b1 || a_od !== 8'h08) begin
      fails++; $display("FAIL stream_last: got v=%b d=%0h expected v=1 d=08", a_ov, a_od); end
    @(negedge clk);
    #1;
    tests++; if (a_ov !== 1'b0) begin
      fails++; $display("FAIL stream_empty: got %b expected 0", a_ov); end
  endtask

  task automatic fill_c(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input int n);
    logic [7:0] vals [3];
    vals[0] = d0; vals[1] = d1; vals[2] = d2;
    c_or = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c_iv = 1'b1; c_id = vals[i];
      #1;
      tests++; if (c_ir !== 1'b1) begin
        fails++; $display("FAIL fill_ready %0d: got %b expected 1", i, c_ir); end
    end
    @(negedge clk);
    c_iv = 1'b0;
  endtask

  task automatic test_fill_drain;
    logic [7:0] exp [3];
    exp[0] = 8'h0A; exp[1] = 8'h0B; exp[2] = 8'h0C;
    fill_c(8'h0A, 8'h0B, 8'h0C, 3);
    #1;
    tests++; if ({c_full, c_cnt, c_ir, c_ov} !== 5'b1_11_0_1) begin
      fails++; $display("FAIL full_state: got %b expected 11101", {c_full, c_cnt, c_ir, c_ov}); end
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      c_or = 1'b1;
      #1;
      tests++; if (c_ov !== 1'b1 || c_od !== exp[i]) begin
        fails++; $display("FAIL drain_%0d: got v=%b d=%0h expected v=1 d=%0h", i, c_ov, c_od, exp[i]); end
    end
    @(negedge clk);
    c_or = 1'b0;
    #1;
    tests++; if (c_empty !== 1'b1 || c_ov !== 1'b0) begin
      fails++; $display("FAIL drain_empty: got e=%b v=%b expected e=1 v=0", c_empty, c_ov); end
  endtask

  task automatic test_full_simul;
    logic [7:0] exp [3];
    exp[0] = 8'h22; exp[1] = 8'h33; exp[2] = 8'h44;
    fill_c(8'h11, 8'h22, 8'h33, 3);
    c_iv = 1'b1; c_id = 8'h44; c_or = 1'b1;
    #1;
    tests++; if (c_ir !== 1'b0) begin
      fails++; $display("FAIL full_pop_ready: got %b expected 0", c_ir); end
    @(negedge clk);
    c_or = 1'b0;
    #1;
    tests++; if (c_ir !== 1'b1 || c_cnt !== 2'd2 || c_od !== 8'h22) begin
      fails++; $display("FAIL after_pop: got r=%b c=%0d d=%0h expected r=1 c=2 d=22", c_ir, c_cnt, c_od); end
    @(negedge clk);
    c_iv = 1'b0;
    #1;
    tests++; if (c_cnt !== 2'd3) begin
      fails++; $display("FAIL refill_count: got %0d expected 3", c_cnt); end
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      c_or = 1'b1;
      #1;
      tests++; if (c_od !== exp[i]) begin
        fails++; $display("FAIL simul_drain_%0d: got %0h expected %0h", i, c_od, exp[i]); end
    end
    @(negedge clk);
    c_or = 1'b0;
  endtask

  task automatic test_hold;
    fill_c(8'h61, 8'h62, 8'h00, 2);
    c_hold = 1'b1; c_iv = 1'b1; c_id = 8'h63; c_or = 1'b1;
    #1;
    tests++; if (c_ir !== 1'b0 || c_od !== 8'h61) begin
      fails++; $display("FAIL hold_1: got r=%b d=%0h expected r=0 d=61", c_ir, c_od); end
    @(negedge clk);
    #1;
    tests++; if (c_ir !== 1'b0 || c_od !== 8'h62 || c_cnt !== 2'd1) begin
      fails++; $display("FAIL hold_2: got r=%b d=%0h c=%0d expected r=0 d=62 c=1", c_ir, c_od, c_cnt); end
    @(negedge clk);
    #1;
    tests++; if (c_cnt !== 2'd0 || c_empty !== 1'b1) begin
      fails++; $display("FAIL hold_empty: got c=%0d e=%b expected c=0 e=1", c_cnt, c_empty); end
    c_hold = 1'b0;
    #1;
    tests++; if (c_ir !== 1'b1) begin
      fails++; $display("FAIL hold_release: got %b expected 1", c_ir); end
    @(negedge clk);
    c_iv = 1'b0;
    #1;
    tests++; if (c_ov !== 1'b1 || c_od !== 8'h63) begin
      fails++; $display("FAIL hold_accept: got v=%b d=%0h expected v=1 d=63", c_ov, c_od); end
    @(negedge clk);
    c_or = 1'b0;
  endtask

  task automatic test_random;
    logic [7:0] q [$];
    int got = 0;
    int cyc = 0;
    logic push, pop;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      e_iv = ($urandom_range(0, 3) != 0);
      e_or = ($urandom_range(0, 3) != 0);
      e_hold = ($urandom_range(0, 9) == 0);
      e_id = 8'($urandom);
      #1;
      tests++; if (e_ov !== (q.size() != 0)) begin
        fails++; $display("FAIL rand_valid cyc %0d: got %b expected %b", cyc, e_ov, (q.size() != 0)); end
      tests++; if (e_ir !== (q.size() < 5 && !e_hold)) begin
        fails++; $display("FAIL rand_ready cyc %0d: got %b expected %b", cyc, e_ir, (q.size() < 5 && !e_hold)); end
      tests++; if (e_cnt !== 3'(q.size())) begin
        fails++; $display("FAIL rand_count cyc %0d: got %0d expected %0d", cyc, e_cnt, q.size()); end
      if (q.size() != 0) begin
        tests++; if (e_od !== q[0]) begin
          fails++; $display("FAIL rand_data cyc %0d: got %0h expected %0h", cyc, e_od, q[0]); end
      end
      push = e_iv && (q.size() < 5) && !e_hold;
      pop  = (q.size() != 0) && e_or;
      if (pop) begin
        void'(q.pop_front());
        got++;
      end
      if (push) q.push_back(e_id);
    end
    tests++; if (got < 1000) begin
      fails++; $display("FAIL rand_timeout: got %0d beats expected 1000", got); end
    @(negedge clk);
    e_iv = 1'b0; e_or = 1'b0; e_hold = 1'b0;
  endtask

  task automatic test_reset_mid;
    fill_c(8'h71, 8'h72, 8'h00, 2);
    #2;
    rst = 1'b1;
    #1;
    tests++; if (c_ov !== 1'b0 || c_cnt !== 2'd0 || c_empty !== 1'b1 || c_ir !== 1'b1) begin
      fails++; $display("FAIL async_reset: got v=%b c=%0d e=%b r=%b expected v=0 c=0 e=1 r=1",
                        c_ov, c_cnt, c_empty, c_ir); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    c_iv = 1'b1; c_id = 8'h5A;
    @(negedge clk);
    c_iv = 1'b0; c_or = 1'b1;
    #1;
    tests++; if (c_ov !== 1'b1 || c_od !== 8'h5A || c_cnt !== 2'd1) begin
      fails++; $display("FAIL post_reset_beat: got v=%b d=%0h c=%0d expected v=1 d=5a c=1", c_ov, c_od, c_cnt); end
    @(negedge clk);
    #1;
    tests++; if (c_ov !== 1'b0) begin
      fails++; $display("FAIL post_reset_alone: got %b expected 0", c_ov); end
    c_or = 1'b0;
  endtask

  task automatic test_bypass;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      b_iv = 1'($urandom); b_or = 1'($urandom); b_hold = ($urandom_range(0, 3) == 0);
      b_id = 8'($urandom);
      #1;
      tests++; if (b_od !== b_id || b_ov !== (b_iv & ~b_hold) || b_ir !== (b_or & ~b_hold)) begin
        fails++; $display("FAIL bypass %0d: got d=%0h v=%b r=%b expected d=%0h v=%b r=%b",
                          i, b_od, b_ov, b_ir, b_id, b_iv & ~b_hold, b_or & ~b_hold); end
      tests++; if (b_cnt !== 2'd0 || b_empty !== 1'b1 || b_full !== 1'b0) begin
        fails++; $display("FAIL bypass_status %0d: got c=%0d e=%b f=%b expected 0 1 0",
                          i, b_cnt, b_empty, b_full); end
    end
  endtask

  initial begin
    {a_iv, a_or, a_hold, a_id} = '0;
    {c_iv, c_or, c_hold, c_id} = '0;
    {e_iv, e_or, e_hold, e_id} = '0;
    {b_iv, b_or, b_hold, b_id} = '0;
    test_reset();
    test_stream();
    test_fill_drain();
    test_full_simul();
    test_hold();
    test_random();
    test_reset_mid();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
